// File: rtl/l15_transducer_responder.sv
// Behavioural L1.5 end of the BlackParrot<->L1.5 transducer link: one request at a time,
// served from a clear-on-reset memory of 128-bit lines, with a fixed response latency.
module l15_transducer_responder #(
    parameter int mem_els_p      = 1024,
    parameter int resp_latency_p = 4
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic [4:0]  transducer_l15_rqtype,
    input  logic        transducer_l15_nc,
    input  logic [2:0]  transducer_l15_size,
    input  logic        transducer_l15_val,
    input  logic [39:0] transducer_l15_address,
    input  logic [63:0] transducer_l15_data,
    input  logic [1:0]  transducer_l15_l1rplway,
    output logic        l15_transducer_ack,
    output logic        l15_transducer_header_ack,
    output logic        l15_transducer_val,
    output logic [3:0]  l15_transducer_returntype,
    output logic [63:0] l15_transducer_data_0,
    output logic [63:0] l15_transducer_data_1,
    input  logic        transducer_l15_req_ack,
    output logic        err_o,
    output logic [2:0]  state_o,
    output logic        dbg_nc_o
);
    localparam int IW = $clog2(mem_els_p);
    localparam int CW = (resp_latency_p > 0) ? $clog2(resp_latency_p + 1) : 1;
    localparam logic [CW-1:0] LAT_INIT  = CW'((resp_latency_p > 0) ? resp_latency_p - 1 : 0);
    localparam logic [IW-1:0] LAST_LINE = IW'(mem_els_p - 1);

    typedef enum logic [2:0] {e_clear, e_int, e_idle, e_wait, e_resp} state_e;

    // Handshake: a request is accepted in the cycle ack=val=1 (only in e_idle); a response
    // is consumed in the cycle val=req_ack=1 and is held unchanged until then.
    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   line_q, line_d;
    logic            load_q, load_d;
    logic            nc_q, nc_d;
    logic            err_q, err_d;
    logic [127:0]    mem_q [mem_els_p];

    logic [IW-1:0]   req_line;
    logic            is_load, store_ok, legal, accept;
    logic [7:0]      byte_en;
    logic [2:0]      byte_off;
    logic            unused_bits;

    assign req_line    = transducer_l15_address[4 +: IW];
    assign is_load     = (transducer_l15_rqtype == 5'b00000);
    assign store_ok    = (transducer_l15_rqtype == 5'b00001) && !transducer_l15_size[2];
    assign legal       = is_load || store_ok;
    assign accept      = reset_n_i && (state_q == e_idle) && transducer_l15_val;
    assign unused_bits = ^{transducer_l15_l1rplway, transducer_l15_address[39:4+IW]};

    // Byte lanes of the selected dword, offset aligned down to the access size.
    always_comb begin
        byte_off = transducer_l15_address[2:0];
        byte_en  = 8'h00;
        case (transducer_l15_size[1:0])
            2'd0: byte_en = 8'h01 << byte_off;
            2'd1: begin
                byte_off[0] = 1'b0;
                byte_en     = 8'h03 << byte_off;
            end
            2'd2: begin
                byte_off[1:0] = 2'b00;
                byte_en       = 8'h0F << byte_off;
            end
            default: byte_en = 8'hFF;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_n_i && state_q == e_clear) begin
            mem_q[ptr_q] <= '0;
        end else if (accept && store_ok) begin
            for (int b = 0; b < 8; b++) begin
                if (byte_en[b]) begin
                    mem_q[req_line][(transducer_l15_address[3] ? 64 : 0) + 8*b +: 8]
                        <= transducer_l15_data[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        load_d  = load_q;
        nc_d    = nc_q;
        err_d   = err_q;
        case (state_q)
            e_clear: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LAST_LINE) state_d = e_int;
            end
            e_int:  if (transducer_l15_req_ack) state_d = e_idle;
            e_idle: begin
                if (accept) begin
                    line_d = req_line;
                    load_d = is_load;
                    nc_d   = transducer_l15_nc;
                    if (!legal) begin
                        err_d = 1'b1;
                    end else if (resp_latency_p == 0) begin
                        state_d = e_resp;
                    end else begin
                        cnt_d   = LAT_INIT;
                        state_d = e_wait;
                    end
                end
            end
            e_wait: begin
                if (cnt_q == '0) state_d = e_resp;
                else             cnt_d   = cnt_q - 1'b1;
            end
            e_resp:  if (transducer_l15_req_ack) state_d = e_idle;
            default: state_d = e_clear;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= e_clear;
            ptr_q   <= '0;
            cnt_q   <= '0;
            line_q  <= '0;
            load_q  <= 1'b0;
            nc_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            load_q  <= load_d;
            nc_q    <= nc_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        l15_transducer_val        = 1'b0;
        l15_transducer_returntype = 4'b0000;
        l15_transducer_data_0     = '0;
        l15_transducer_data_1     = '0;
        if (state_q == e_int) begin
            l15_transducer_val        = 1'b1;
            l15_transducer_returntype = 4'b0111;
        end else if (state_q == e_resp) begin
            l15_transducer_val        = 1'b1;
            l15_transducer_returntype = load_q ? 4'b0000 : 4'b0100;
            if (load_q) begin
                l15_transducer_data_0 = mem_q[line_q][63:0];
                l15_transducer_data_1 = mem_q[line_q][127:64];
            end
        end
    end

    assign l15_transducer_ack        = accept;
    assign l15_transducer_header_ack = accept;
    assign err_o                     = err_q;
    assign state_o                   = state_q;
    assign dbg_nc_o                  = nc_q;

endmodule

// File: tb/tb_l15_transducer_responder.sv
// Bench for l15_transducer_responder: two instances (latency 4 and 0, 16 lines each)
// against a byte-level memory model with latency and handshake expectations.
module tb_l15_transducer_responder;
    localparam int MEM = 16;
    localparam logic [4:0] LOAD_RQ  = 5'b00000;
    localparam logic [4:0] STORE_RQ = 5'b00001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [2];
    logic [4:0]  rq    [2];
    logic        nc    [2];
    logic [2:0]  sz    [2];
    logic        vin   [2];
    logic [39:0] addr  [2];
    logic [63:0] wdata [2];
    logic [1:0]  rpl   [2];
    logic        rack  [2];
    logic        ack   [2];
    logic        hack  [2];
    logic        vout  [2];
    logic [3:0]  rtype [2];
    logic [63:0] d0    [2];
    logic [63:0] d1    [2];
    logic        err   [2];
    logic [2:0]  st    [2];
    logic        dnc   [2];

    int lat [2] = '{4, 0};
    logic [127:0] mem_m [2][MEM];
    int checks = 0;
    int errors = 0;

    l15_transducer_responder #(.mem_els_p(MEM), .resp_latency_p(4)) u_dut0 (
        .clk_i(clk), .reset_n_i(rst_n[0]),
        .transducer_l15_rqtype(rq[0]), .transducer_l15_nc(nc[0]),
        .transducer_l15_size(sz[0]), .transducer_l15_val(vin[0]),
        .transducer_l15_address(addr[0]), .transducer_l15_data(wdata[0]),
        .transducer_l15_l1rplway(rpl[0]),
        .l15_transducer_ack(ack[0]), .l15_transducer_header_ack(hack[0]),
        .l15_transducer_val(vout[0]), .l15_transducer_returntype(rtype[0]),
        .l15_transducer_data_0(d0[0]), .l15_transducer_data_1(d1[0]),
        .transducer_l15_req_ack(rack[0]), .err_o(err[0]),
        .state_o(st[0]), .dbg_nc_o(dnc[0])
    );

    l15_transducer_responder #(.mem_els_p(MEM), .resp_latency_p(0)) u_dut1 (
        .clk_i(clk), .reset_n_i(rst_n[1]),
        .transducer_l15_rqtype(rq[1]), .transducer_l15_nc(nc[1]),
        .transducer_l15_size(sz[1]), .transducer_l15_val(vin[1]),
        .transducer_l15_address(addr[1]), .transducer_l15_data(wdata[1]),
        .transducer_l15_l1rplway(rpl[1]),
        .l15_transducer_ack(ack[1]), .l15_transducer_header_ack(hack[1]),
        .l15_transducer_val(vout[1]), .l15_transducer_returntype(rtype[1]),
        .l15_transducer_data_0(d0[1]), .l15_transducer_data_1(d1[1]),
        .transducer_l15_req_ack(rack[1]), .err_o(err[1]),
        .state_o(st[1]), .dbg_nc_o(dnc[1])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference store: n = 2^size bytes at the size-aligned offset of dword addr[3].
    function automatic void model_store(input int i, input logic [39:0] a,
                                        input logic [2:0] s, input logic [63:0] d);
        int n, off, ln, base;
        n    = 1 << s[1:0];
        off  = int'(a[2:0]);
        off  = off - (off % n);
        ln   = int'(a[7:4]);
        base = a[3] ? 64 : 0;
        for (int b = 0; b < n; b++)
            mem_m[i][ln][base + (off + b)*8 +: 8] = d[(off + b)*8 +: 8];
    endfunction

    task automatic idle_inputs(input int i);
        vin[i] = 1'b0; rack[i] = 1'b0; rq[i] = '0; nc[i] = 1'b0;
        sz[i] = '0; addr[i] = '0; wdata[i] = '0; rpl[i] = '0;
    endtask

    // Called right after reset is released: 16 silent clear cycles, then INT_RET.
    task automatic wake(input int i);
        for (int k = 1; k <= MEM; k++) begin
            if (k > 1) tick();
            checks++;
            if ({vout[i], ack[i], hack[i], rtype[i], d0[i], d1[i], err[i]} !== '0) begin
                errors++;
                $display("FAIL clear_quiet inst=%0d cycle=%0d got val=%b ack=%b rtype=%h err=%b exp all 0",
                         i, k, vout[i], ack[i], rtype[i], err[i]);
            end
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if ({vout[i], rtype[i], d1[i], d0[i]} !== {1'b1, 4'b0111, 128'h0}) begin
                errors++;
                $display("FAIL int_ret inst=%0d hold=%0d got val=%b rtype=%h d1=%h d0=%h exp val=1 rtype=7 data=0",
                         i, k, vout[i], rtype[i], d1[i], d0[i]);
            end
        end
        rack[i] = 1'b1;
        tick();
        rack[i] = 1'b0;
        checks++;
        if ({vout[i], err[i]} !== 2'b00) begin
            errors++;
            $display("FAIL int_consumed inst=%0d got val=%b err=%b exp 0 0", i, vout[i], err[i]);
        end
        for (int l = 0; l < MEM; l++) mem_m[i][l] = '0;
    endtask

    task automatic test_reset(input int i);
        idle_inputs(i);
        rst_n[i] = 1'b0;
        tick();
        tick();
        checks++;
        if ({vout[i], ack[i], rtype[i], d0[i], d1[i], err[i]} !== '0) begin
            errors++;
            $display("FAIL in_reset inst=%0d got val=%b ack=%b rtype=%h err=%b exp all 0",
                     i, vout[i], ack[i], rtype[i], err[i]);
        end
        rst_n[i] = 1'b1;
        wake(i);
    endtask

    task automatic do_req(input int i, input logic [4:0] t, input logic [2:0] s,
                          input logic [39:0] a, input logic [63:0] d,
                          output logic [63:0] obs0, output logic [63:0] obs1);
        logic [127:0] exp;
        logic is_load;
        int cyc, hold;
        rq[i] = t; sz[i] = s; addr[i] = a; wdata[i] = d;
        nc[i] = 1'($urandom_range(0, 1)); rpl[i] = 2'($urandom_range(0, 3));
        vin[i] = 1'b1;
        #1;
        checks++;
        if ({ack[i], hack[i]} !== 2'b11) begin
            errors++;
            $display("FAIL req_ack inst=%0d got ack=%b hack=%b exp 1 1", i, ack[i], hack[i]);
        end
        is_load = (t == LOAD_RQ);
        if (!is_load) model_store(i, a, s, d);
        tick();
        vin[i] = 1'b0;
        rq[i] = 5'($urandom_range(0, 31));
        cyc = 1;
        while (vout[i] !== 1'b1 && cyc < 50) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc != 1 + lat[i]) begin
            errors++;
            $display("FAIL latency inst=%0d got %0d cycles exp %0d", i, cyc, 1 + lat[i]);
        end
        exp  = is_load ? mem_m[i][a[7:4]] : '0;
        obs0 = d0[i];
        obs1 = d1[i];
        hold = $urandom_range(0, 3);
        for (int h = 0; h <= hold; h++) begin
            checks++;
            if ({vout[i], rtype[i], d1[i], d0[i]} !== {1'b1, (is_load ? 4'b0000 : 4'b0100), exp}) begin
                errors++;
                $display("FAIL resp inst=%0d addr=%h got val=%b rtype=%h d1=%h d0=%h exp rtype=%h d1=%h d0=%h",
                         i, a, vout[i], rtype[i], d1[i], d0[i], (is_load ? 4'b0000 : 4'b0100),
                         exp[127:64], exp[63:0]);
            end
            if (h < hold) tick();
        end
        rack[i] = 1'b1;
        tick();
        rack[i] = 1'b0;
        checks++;
        if (vout[i] !== 1'b0) begin
            errors++;
            $display("FAIL resp_consumed inst=%0d got val=%b exp 0", i, vout[i]);
        end
    endtask

    task automatic test_store_load();
        logic [63:0] o0, o1;
        do_req(0, STORE_RQ, 3'b011, 40'h40, 64'h1122334455667788, o0, o1);
        do_req(0, LOAD_RQ, 3'b111, 40'h40, 64'($urandom), o0, o1);
        checks++;
        if ({o1, o0} !== {64'h0, 64'h1122334455667788}) begin
            errors++;
            $display("FAIL store8_load got d1=%h d0=%h exp d1=0 d0=1122334455667788", o1, o0);
        end
    endtask

    task automatic test_byte_store();
        logic [63:0] o0, o1;
        do_req(0, STORE_RQ, 3'b011, 40'h00, 64'h1122334455667788, o0, o1);
        do_req(0, STORE_RQ, 3'b000, 40'h0B, {8{8'hAB}}, o0, o1);
        do_req(0, LOAD_RQ, 3'b011, 40'h00, '0, o0, o1);
        checks++;
        if ({o1, o0} !== {64'h00000000AB000000, 64'h1122334455667788}) begin
            errors++;
            $display("FAIL byte_store got d1=%h d0=%h exp d1=00000000ab000000 d0=1122334455667788", o1, o0);
        end
    endtask

    task automatic illegal_req(input int i, input logic [4:0] t, input logic [2:0] s,
                               input logic [39:0] a);
        rq[i] = t; sz[i] = s; addr[i] = a; wdata[i] = {$urandom, $urandom};
        vin[i] = 1'b1;
        #1;
        checks++;
        if (ack[i] !== 1'b1) begin
            errors++;
            $display("FAIL illegal_ack inst=%0d got ack=%b exp 1", i, ack[i]);
        end
        tick();
        vin[i] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if ({err[i], vout[i]} !== 2'b10) begin
                errors++;
                $display("FAIL illegal_err inst=%0d cycle=%0d got err=%b val=%b exp err=1 val=0",
                         i, k, err[i], vout[i]);
            end
            tick();
        end
    endtask

    task automatic test_illegal();
        logic [63:0] o0, o1;
        illegal_req(0, 5'b00100, 3'($urandom_range(0, 7)), 40'h40);
        do_req(0, LOAD_RQ, 3'b011, 40'h40, '0, o0, o1);
        illegal_req(0, STORE_RQ, 3'b111, 40'h40);
        illegal_req(0, STORE_RQ, 3'b101, 40'h48);
        do_req(0, LOAD_RQ, 3'b111, 40'h40, '0, o0, o1);
    endtask

    task automatic test_random(input int i, input int n);
        logic [63:0] o0, o1;
        logic [39:0] a;
        for (int k = 0; k < n; k++) begin
            a = {8'($urandom), 32'($urandom)};
            if ($urandom_range(0, 1) == 1)
                do_req(i, STORE_RQ, 3'($urandom_range(0, 3)), a, {$urandom, $urandom}, o0, o1);
            else
                do_req(i, LOAD_RQ, 3'($urandom_range(0, 7)), a, {$urandom, $urandom}, o0, o1);
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] exp;
        logic [63:0] sd;
        sd = {$urandom, $urandom};
        rq[1] = STORE_RQ; sz[1] = 3'b010; addr[1] = 40'h84; wdata[1] = sd; vin[1] = 1'b1;
        #1;
        checks++;
        if (ack[1] !== 1'b1) begin
            errors++;
            $display("FAIL bp_store_ack got ack=%b exp 1", ack[1]);
        end
        model_store(1, 40'h84, 3'b010, sd);
        tick();
        rq[1] = LOAD_RQ; sz[1] = 3'b111; addr[1] = 40'h80; wdata[1] = '0;
        for (int k = 0; k < 10; k++) begin
            #1;
            checks++;
            if ({ack[1], vout[1], rtype[1], d1[1], d0[1]} !== {1'b0, 1'b1, 4'b0100, 128'h0}) begin
                errors++;
                $display("FAIL bp_stall cycle=%0d got ack=%b val=%b rtype=%h d1=%h d0=%h exp ack=0 val=1 rtype=4 data=0",
                         k, ack[1], vout[1], rtype[1], d1[1], d0[1]);
            end
            tick();
        end
        rack[1] = 1'b1;
        #1;
        checks++;
        if (ack[1] !== 1'b0) begin
            errors++;
            $display("FAIL bp_same_cycle got ack=%b exp 0", ack[1]);
        end
        tick();
        rack[1] = 1'b0;
        #1;
        checks++;
        if (ack[1] !== 1'b1) begin
            errors++;
            $display("FAIL bp_next_ack got ack=%b exp 1", ack[1]);
        end
        tick();
        vin[1] = 1'b0;
        exp = mem_m[1][8];
        checks++;
        if ({vout[1], rtype[1], d1[1], d0[1]} !== {1'b1, 4'b0000, exp}) begin
            errors++;
            $display("FAIL bp_load got val=%b rtype=%h d1=%h d0=%h exp val=1 rtype=0 d1=%h d0=%h",
                     vout[1], rtype[1], d1[1], d0[1], exp[127:64], exp[63:0]);
        end
        rack[1] = 1'b1;
        tick();
        rack[1] = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic [63:0] o0, o1;
        do_req(0, STORE_RQ, 3'b011, 40'h40, {$urandom, $urandom} | 64'h1, o0, o1);
        rq[0] = LOAD_RQ; sz[0] = 3'b111; addr[0] = 40'h40; vin[0] = 1'b1;
        #1;
        checks++;
        if (ack[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_ack got ack=%b exp 1", ack[0]);
        end
        tick();
        vin[0] = 1'b0;
        tick();
        rst_n[0] = 1'b0;
        tick();
        rst_n[0] = 1'b1;
        wake(0);
        do_req(0, LOAD_RQ, 3'b111, 40'h40, '0, o0, o1);
        checks++;
        if ({o1, o0} !== 128'h0) begin
            errors++;
            $display("FAIL mid_reset_cleared got d1=%h d0=%h exp 0", o1, o0);
        end
    endtask

    initial begin
        rst_n[0] = 1'b0;
        rst_n[1] = 1'b0;
        idle_inputs(0);
        idle_inputs(1);
        test_reset(0);
        test_store_load();
        test_byte_store();
        test_illegal();
        test_random(0, 40);
        test_mid_reset();
        test_reset(1);
        test_backpressure();
        test_random(1, 40);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
